// File: rtl/cpu_core_sc.sv
// cpu_core_sc: single-clock 6502-subset CPU core, one bus cycle per clock.
// Fetches its start address from a reset vector, supports immediate,
// implied and absolute (LDA/STA/JMP) instructions, bus stalls via rdy,
// and reports unknown opcodes.
// Ports:
//   clk_ph1             system clock, rising edge
//   rst                 synchronous active-low reset
//   rdy                 bus ready; low stalls a read cycle
//   data_in             read data, sampled at the edge ending the cycle
//   addr_bus            registered bus address
//   data_out, we        registered write data / write strobe
//   sync                high during opcode-fetch cycles
//   illegal             one-cycle pulse while an unknown opcode is in OP1
//   A_dbg..P_dbg, PC_dbg register views
module cpu_core_sc #(
  parameter int          ADDR_W       = 16,
  parameter logic [15:0] RESET_VEC    = 16'hFFFC,
  parameter int          ILLEGAL_HALT = 0
) (
  input  logic              clk_ph1,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        data_in,
  output logic [ADDR_W-1:0] addr_bus,
  output logic [7:0]        data_out,
  output logic              we,
  output logic              sync,
  output logic              illegal,
  output logic [7:0]        A_dbg,
  output logic [7:0]        X_dbg,
  output logic [7:0]        Y_dbg,
  output logic [7:0]        P_dbg,
  output logic [ADDR_W-1:0] PC_dbg
);

  typedef enum logic [2:0] {
    S_VEC_LO = 3'd0,
    S_VEC_HI = 3'd1,
    S_FETCH  = 3'd2,
    S_OP1    = 3'd3,
    S_OP2    = 3'd4,
    S_MEM    = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] VEC_LO_ADDR = RESET_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] VEC_HI_ADDR = VEC_LO_ADDR + PC_ONE;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9, OP_LDX_IMM = 8'hA2, OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_ADC_IMM = 8'h69, OP_SBC_IMM = 8'hE9;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD, OP_STA_ABS = 8'h8D, OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_INX = 8'hE8, OP_INY = 8'hC8, OP_DEX = 8'hCA, OP_DEY = 8'h88;
  localparam logic [7:0] OP_TAX = 8'hAA, OP_TXA = 8'h8A, OP_TAY = 8'hA8, OP_TYA = 8'h98;
  localparam logic [7:0] OP_CLC = 8'h18, OP_SEC = 8'h38, OP_CLV = 8'hB8, OP_NOP = 8'hEA;

  state_t              state_r;
  logic [ADDR_W-1:0]   addr_r, pc_r;
  logic [7:0]          data_out_r, a_r, x_r, y_r, p_r, ir_r, pcl_r, adl_r;
  logic                we_r, sync_r, illegal_r;
  logic [7:0]          m_s;
  logic [8:0]          sum_s;
  logic                v_s;
  logic [ADDR_W-1:0]   pc_inc_s, vec_pc_s, ea_s;

  // Update N and Z from a result; bit 5 always reads 1.
  function automatic logic [7:0] nz_flags(input logic [7:0] p, input logic [7:0] r);
    logic [7:0] q;
    q    = p;
    q[7] = r[7];
    q[1] = (r == 8'h00);
    q[5] = 1'b1;
    return q;
  endfunction

  function automatic logic known_op(input logic [7:0] op);
    case (op)
      OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_ADC_IMM, OP_SBC_IMM,
      OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS,
      OP_INX, OP_INY, OP_DEX, OP_DEY,
      OP_TAX, OP_TXA, OP_TAY, OP_TYA,
      OP_CLC, OP_SEC, OP_CLV, OP_NOP: known_op = 1'b1;
      default:                        known_op = 1'b0;
    endcase
  endfunction

  // Adder shared by ADC and SBC (SBC adds the inverted operand) and address helpers.
  always_comb begin
    m_s      = (ir_r == OP_SBC_IMM) ? ~data_in : data_in;
    sum_s    = {1'b0, a_r} + {1'b0, m_s} + {8'h00, p_r[0]};
    v_s      = (a_r[7] == m_s[7]) && (sum_s[7] != a_r[7]);
    pc_inc_s = pc_r + PC_ONE;
    vec_pc_s = {data_in[ADDR_W-9:0], pcl_r};
    ea_s     = {data_in[ADDR_W-9:0], adl_r};
  end

  // Sequencer: all architectural state and bus outputs; a read cycle with rdy low freezes everything.
  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      state_r    <= S_VEC_LO;
      addr_r     <= VEC_LO_ADDR;
      we_r       <= 1'b0;
      data_out_r <= 8'h00;
      sync_r     <= 1'b0;
      illegal_r  <= 1'b0;
      a_r        <= 8'h00;
      x_r        <= 8'h00;
      y_r        <= 8'h00;
      p_r        <= 8'h20;
      pc_r       <= '0;
      ir_r       <= 8'h00;
      pcl_r      <= 8'h00;
      adl_r      <= 8'h00;
    end else if (rdy || we_r) begin
      illegal_r <= 1'b0;
      case (state_r)
        S_VEC_LO: begin
          pcl_r   <= data_in;
          addr_r  <= VEC_HI_ADDR;
          state_r <= S_VEC_HI;
        end
        S_VEC_HI: begin
          pc_r    <= vec_pc_s;
          addr_r  <= vec_pc_s;
          sync_r  <= 1'b1;
          state_r <= S_FETCH;
        end
        S_FETCH: begin
          ir_r      <= data_in;
          pc_r      <= pc_inc_s;
          addr_r    <= pc_inc_s;
          sync_r    <= 1'b0;
          illegal_r <= !known_op(data_in);
          state_r   <= S_OP1;
        end
        S_OP1: begin
          // Implied ops: the operand read was a dummy, refetch at the same PC.
          addr_r  <= pc_r;
          sync_r  <= 1'b1;
          state_r <= S_FETCH;
          case (ir_r)
            OP_LDA_IMM: begin a_r <= data_in; p_r <= nz_flags(p_r, data_in); pc_r <= pc_inc_s; addr_r <= pc_inc_s; end
            OP_LDX_IMM: begin x_r <= data_in; p_r <= nz_flags(p_r, data_in); pc_r <= pc_inc_s; addr_r <= pc_inc_s; end
            OP_LDY_IMM: begin y_r <= data_in; p_r <= nz_flags(p_r, data_in); pc_r <= pc_inc_s; addr_r <= pc_inc_s; end
            OP_ADC_IMM, OP_SBC_IMM: begin
              a_r    <= sum_s[7:0];
              p_r    <= {sum_s[7], v_s, 1'b1, p_r[4:2], (sum_s[7:0] == 8'h00), sum_s[8]};
              pc_r   <= pc_inc_s;
              addr_r <= pc_inc_s;
            end
            OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS: begin
              adl_r   <= data_in;
              pc_r    <= pc_inc_s;
              addr_r  <= pc_inc_s;
              sync_r  <= 1'b0;
              state_r <= S_OP2;
            end
            OP_INX: begin x_r <= x_r + 8'h01; p_r <= nz_flags(p_r, x_r + 8'h01); end
            OP_INY: begin y_r <= y_r + 8'h01; p_r <= nz_flags(p_r, y_r + 8'h01); end
            OP_DEX: begin x_r <= x_r - 8'h01; p_r <= nz_flags(p_r, x_r - 8'h01); end
            OP_DEY: begin y_r <= y_r - 8'h01; p_r <= nz_flags(p_r, y_r - 8'h01); end
            OP_TAX: begin x_r <= a_r; p_r <= nz_flags(p_r, a_r); end
            OP_TXA: begin a_r <= x_r; p_r <= nz_flags(p_r, x_r); end
            OP_TAY: begin y_r <= a_r; p_r <= nz_flags(p_r, a_r); end
            OP_TYA: begin a_r <= y_r; p_r <= nz_flags(p_r, y_r); end
            OP_CLC: p_r[0] <= 1'b0;
            OP_SEC: p_r[0] <= 1'b1;
            OP_CLV: p_r[6] <= 1'b0;
            OP_NOP: p_r    <= p_r;
            default: begin
              // Unknown opcode: either a 2-cycle NOP or a freeze with the address held.
              if (ILLEGAL_HALT != 0) begin
                sync_r  <= 1'b0;
                state_r <= S_HALT;
              end else begin
                p_r <= p_r;
              end
            end
          endcase
        end
        S_OP2: begin
          if (ir_r == OP_JMP_ABS) begin
            pc_r    <= ea_s;
            addr_r  <= ea_s;
            sync_r  <= 1'b1;
            state_r <= S_FETCH;
          end else begin
            pc_r       <= pc_inc_s;
            addr_r     <= ea_s;
            we_r       <= (ir_r == OP_STA_ABS);
            data_out_r <= (ir_r == OP_STA_ABS) ? a_r : 8'h00;
            state_r    <= S_MEM;
          end
        end
        S_MEM: begin
          if (ir_r == OP_LDA_ABS) begin
            a_r <= data_in;
            p_r <= nz_flags(p_r, data_in);
          end else begin
            a_r <= a_r;
          end
          we_r       <= 1'b0;
          data_out_r <= 8'h00;
          addr_r     <= pc_r;
          sync_r     <= 1'b1;
          state_r    <= S_FETCH;
        end
        S_HALT: state_r <= S_HALT;
        default: begin
          state_r <= S_VEC_LO;
          addr_r  <= VEC_LO_ADDR;
          we_r    <= 1'b0;
          sync_r  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_bus = addr_r;
  assign data_out = data_out_r;
  assign we       = we_r;
  assign sync     = sync_r;
  assign illegal  = illegal_r;
  assign A_dbg    = a_r;
  assign X_dbg    = x_r;
  assign Y_dbg    = y_r;
  assign P_dbg    = p_r | 8'h20;
  assign PC_dbg   = pc_r;

endmodule

// File: tb/tb_cpu_core_sc.sv
// tb_cpu_core_sc: directed program run against cpu_core_sc with a
// combinational read-only memory model and hand-computed expectations.
module tb_cpu_core_sc;

  logic        clk_ph1;
  logic        rst;
  logic        rdy;
  logic [7:0]  data_in;
  logic [15:0] addr_bus;
  logic [7:0]  data_out;
  logic        we;
  logic        sync;
  logic        illegal;
  logic [7:0]  A_dbg, X_dbg, Y_dbg, P_dbg;
  logic [15:0] PC_dbg;

  logic [7:0]  mem [0:65535];
  int          n_cmp;
  int          n_err;

  cpu_core_sc #(.ADDR_W(16), .RESET_VEC(16'hFFFC), .ILLEGAL_HALT(1)) dut (
    .clk_ph1  (clk_ph1),
    .rst      (rst),
    .rdy      (rdy),
    .data_in  (data_in),
    .addr_bus (addr_bus),
    .data_out (data_out),
    .we       (we),
    .sync     (sync),
    .illegal  (illegal),
    .A_dbg    (A_dbg),
    .X_dbg    (X_dbg),
    .Y_dbg    (Y_dbg),
    .P_dbg    (P_dbg),
    .PC_dbg   (PC_dbg)
  );

  assign data_in = mem[addr_bus];

  initial clk_ph1 = 1'b0;
  always #5 clk_ph1 = ~clk_ph1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_ph1);
    #1;
  endtask

  // Run one instruction from its sync cycle to the next sync, recording writes.
  task automatic run_instr(output int cyc, output int wes, output logic [15:0] wa, output logic [7:0] wd);
    cyc = 0; wes = 0; wa = 16'h0000; wd = 8'h00;
    do begin
      if (we) begin
        wes++;
        wa = addr_bus;
        wd = data_out;
      end
      step();
      cyc++;
    end while (!sync && cyc < 20);
  endtask

  initial begin
    int          cyc, wes, stall_bad, ill_cnt, halt_bad;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [7:0]  prog [23];
    n_cmp = 0;
    n_err = 0;
    prog = '{8'hA9, 8'h7F, 8'h18, 8'h69, 8'h01, 8'h38, 8'hE9, 8'h01,
             8'hA9, 8'h5A, 8'h8D, 8'h34, 8'h12, 8'hAD, 8'h34, 8'h12,
             8'hA2, 8'h00, 8'hCA, 8'hE8, 8'h4C, 8'h00, 8'h90};
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    for (int i = 0; i < 23; i++) mem[16'h8000 + i] = prog[i];
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    mem[16'h1234] = 8'h5A;
    mem[16'h9000] = 8'h02;

    rst = 1'b0;
    rdy = 1'b1;
    step();
    step();
    check_val("rst_addr", addr_bus, 16'hFFFC);
    check_val("rst_ctl", {we, sync, illegal}, 3'b000);
    check_val("rst_regs", {A_dbg, X_dbg, Y_dbg, P_dbg}, 32'h00000020);
    check_val("rst_pc", PC_dbg, 16'h0000);

    rst = 1'b1;
    step();
    check_val("vec_hi_addr", addr_bus, 16'hFFFD);
    step();
    check_val("vec_pc_addr", addr_bus, 16'h8000);
    check_val("vec_sync", sync, 1'b1);

    run_instr(cyc, wes, wa, wd);
    check_val("lda_imm_cyc", cyc, 2);
    check_val("lda_imm_a_p", {A_dbg, P_dbg}, 16'h7F20);
    run_instr(cyc, wes, wa, wd);
    check_val("clc_cyc", cyc, 2);
    run_instr(cyc, wes, wa, wd);
    check_val("adc_a_p", {A_dbg, P_dbg}, 16'h80E0);
    run_instr(cyc, wes, wa, wd);
    check_val("sec_p", P_dbg, 8'hE1);
    run_instr(cyc, wes, wa, wd);
    check_val("sbc_a_p", {A_dbg, P_dbg}, 16'h7F61);
    run_instr(cyc, wes, wa, wd);
    check_val("lda5a_a_p", {A_dbg, P_dbg}, 16'h5A61);

    run_instr(cyc, wes, wa, wd);
    check_val("sta_cyc", cyc, 4);
    check_val("sta_we_cnt", wes, 1);
    check_val("sta_waddr", wa, 16'h1234);
    check_val("sta_wdata", wd, 8'h5A);
    check_val("sta_we_after", we, 1'b0);
    check_val("sta_pc", PC_dbg, 16'h800D);

    run_instr(cyc, wes, wa, wd);
    check_val("lda_abs_cyc", cyc, 4);
    check_val("lda_abs_a_p", {A_dbg, P_dbg}, 16'h5A61);
    check_val("lda_abs_we", wes, 0);

    run_instr(cyc, wes, wa, wd);
    check_val("ldx0_x_p", {X_dbg, P_dbg}, 16'h0063);
    run_instr(cyc, wes, wa, wd);
    check_val("dex_x_p", {X_dbg, P_dbg}, 16'hFFE1);
    run_instr(cyc, wes, wa, wd);
    check_val("inx_x_p", {X_dbg, P_dbg}, 16'h0063);

    // JMP at 8014 with a 3-cycle stall during the high-operand read.
    check_val("jmp_fetch_addr", addr_bus, 16'h8014);
    cyc = 0;
    step(); cyc++;
    step(); cyc++;
    check_val("jmp_op2_addr", addr_bus, 16'h8016);
    rdy = 1'b0;
    stall_bad = 0;
    for (int i = 0; i < 3; i++) begin
      step(); cyc++;
      if (addr_bus !== 16'h8016 || sync !== 1'b0) stall_bad++;
    end
    check_val("jmp_stall_frozen", stall_bad, 0);
    rdy = 1'b1;
    step(); cyc++;
    check_val("jmp_cyc", cyc, 6);
    check_val("jmp_target", {sync, addr_bus}, 17'h19000);
    check_val("jmp_pc", PC_dbg, 16'h9000);

    // Opcode 02 with halting enabled.
    check_val("ill_pre", illegal, 1'b0);
    step();
    check_val("ill_pulse", illegal, 1'b1);
    ill_cnt = 1;
    halt_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (illegal) ill_cnt++;
      if (addr_bus !== 16'h9001 || sync !== 1'b0 || we !== 1'b0) halt_bad++;
    end
    check_val("ill_pulse_cnt", ill_cnt, 1);
    check_val("halt_hold", halt_bad, 0);

    // Restart and reset in the middle of the STA write cycle.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    check_val("restart_addr", {sync, addr_bus}, 17'h18000);
    for (int i = 0; i < 6; i++) run_instr(cyc, wes, wa, wd);
    cyc = 0;
    while (!we && cyc < 10) begin
      step();
      cyc++;
    end
    check_val("sta2_we", we, 1'b1);
    rst = 1'b0;
    step();
    check_val("midop_rst_we", we, 1'b0);
    check_val("midop_rst_addr", addr_bus, 16'hFFFC);
    check_val("midop_rst_regs", {A_dbg, P_dbg}, 16'h0020);
    rst = 1'b1;
    step();
    check_val("midop_vec_hi", addr_bus, 16'hFFFD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
